// File: rtl/debounce_counter.sv
// debounce_counter: multi-channel switch debouncer with modulo event counters.
// Each channel synchronizes its raw switch input, filters it on a shared
// prescaler tick, and counts the selected edges of the filtered level.
// Everything runs on clk; the prescaler only produces a one-cycle enable.

module debounce_counter #(
    parameter int CH         = 4,
    parameter int DIV_BITS   = 16,
    parameter int STABLE     = 3,
    parameter int MODULO     = 10,
    parameter int CW         = 4,
    parameter int EDGE       = 0,
    parameter int ACTIVE_LOW = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CH-1:0]    sw,
    input  logic [CH-1:0]    clr,
    output logic             tick,
    output logic [CH-1:0]    db,
    output logic [CH-1:0]    rise,
    output logic [CH-1:0]    fall,
    output logic [CH*CW-1:0] cnt,
    output logic [CH-1:0]    wrap
);

    // Stability counter width; a single-sample filter still needs one bit.
    localparam int SBW = (STABLE > 1) ? $clog2(STABLE) : 1;

    // Last stability count before a new level is accepted.
    localparam logic [SBW-1:0] STAB_LAST = SBW'(STABLE - 1);

    // Counter value that wraps back to zero on the next event.
    localparam logic [CW-1:0] CNT_LAST = CW'(MODULO - 1);

    logic [DIV_BITS-1:0] div;
    logic [CH-1:0]       sw_in;
    logic [CH-1:0]       sync_a;
    logic [CH-1:0]       sync_b;

    // Polarity is fixed up before synchronizing so "1" is always the active level.
    assign sw_in = (ACTIVE_LOW != 0) ? ~sw : sw;

    // Free-running prescaler that only advances while enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else if (en) begin
            div <= div + DIV_BITS'(1);
        end
    end

    // The sample strobe is the all-ones prescaler state qualified by en,
    // so dropping en stops ticks immediately and reset (div=0) keeps it low.
    assign tick = en & (&div);

    // Two-flop synchronizer, clocked every cycle independent of en.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= sw_in;
            sync_b <= sync_a;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [SBW-1:0] stab;
        logic           db_q;
        logic           rise_q;
        logic           fall_q;
        logic [CW-1:0]  cnt_q;
        logic           wrap_q;
        logic           evt;

        // Stability filter: a new level must differ on STABLE consecutive ticks;
        // edge pulses are produced on the same edge that changes the level.
        always_ff @(posedge clk) begin
            if (rst) begin
                stab   <= '0;
                db_q   <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (tick) begin
                    if (sync_b[i] == db_q) begin
                        stab <= '0;
                    end else if (stab == STAB_LAST) begin
                        stab   <= '0;
                        db_q   <= sync_b[i];
                        rise_q <= sync_b[i];
                        fall_q <= ~sync_b[i];
                    end else begin
                        stab <= stab + SBW'(1);
                    end
                end
            end
        end

        // Select which debounced edge counts as an event for this channel.
        always_comb begin
            evt = 1'b0;
            case (EDGE)
                0:       evt = rise_q;
                1:       evt = fall_q;
                default: evt = rise_q | fall_q;
            endcase
        end

        // Modulo event counter; clear wins over a simultaneous event and hides the wrap.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q  <= '0;
                wrap_q <= 1'b0;
            end else if (clr[i]) begin
                cnt_q  <= '0;
                wrap_q <= 1'b0;
            end else if (evt) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_q  <= '0;
                    wrap_q <= 1'b1;
                end else begin
                    cnt_q  <= cnt_q + CW'(1);
                    wrap_q <= 1'b0;
                end
            end else begin
                wrap_q <= 1'b0;
            end
        end

        assign db[i]             = db_q;
        assign rise[i]           = rise_q;
        assign fall[i]           = fall_q;
        assign wrap[i]           = wrap_q;
        assign cnt[i*CW +: CW]   = cnt_q;
    end

endmodule

// File: doc/debounce_counter.md
Name: debounce_counter

Overview:
- Multi-channel successor to the single-switch debounce-and-count block.
- Each channel passes a raw switch input through a two-flop synchronizer and a tick-sampled stability filter, then drives a modulo-N event counter.
- Channel count, prescale, stability depth, modulo, edge selection and input polarity are parameters.
- Fully single-clock: the prescaler produces a tick enable, not a derived clock.

Parameters:
CH, 4, number of independent channels
DIV_BITS, 16, prescaler width; one tick every 2^DIV_BITS enabled clk cycles
STABLE, 3, consecutive differing tick samples required to accept a new level (>=1)
MODULO, 10, counter wraps from MODULO-1 to 0 (2 <= MODULO <= 2^CW)
CW, 4, counter width per channel
EDGE, 0, counted event: 0 = rising, 1 = falling, 2 = both
ACTIVE_LOW, 0, 1 inverts raw sw before synchronizing

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  prescaler/count enable
sw  in  CH  raw asynchronous switch inputs
clr  in  CH  per-channel synchronous counter clear
tick  out  1  one-cycle sample strobe
db  out  CH  debounced levels
rise  out  CH  one-cycle pulse on db 0->1
fall  out  CH  one-cycle pulse on db 1->0
cnt  out  CH*CW  counters; channel i at bits [i*CW +: CW]
wrap  out  CH  one-cycle pulse when counter i wraps to 0

Behaviour:
- Reset: on rst=1 at a clk edge, clear all state. This includes the prescaler, sync flops, stability counters, db, rise, fall, cnt, wrap and tick.
- Polarity: ACTIVE_LOW applies before synchronization, so the internal "1" level is always the active level.
- Synchronizer: 2 flops per channel, clocked every clk regardless of en.
- Prescaler: DIV_BITS counter.
  - Increments when en=1 and holds when en=0.
  - tick=1 for the one cycle where the counter is all ones and en=1.
- Stability filter, per channel, evaluated only on tick cycles with sample s = sync output:
  - s == db: stab <= 0.
  - s != db and stab < STABLE-1: stab <= stab+1.
  - s != db and stab == STABLE-1: db <= s, stab <= 0.
  - Result: a change is accepted after STABLE consecutive differing ticks. Any intermediate agreeing tick restarts the count.
  - Width of stab is clog2(STABLE), minimum 1.
- Edge pulses: rise/fall are registered on the same edge that updates db.
  - Each is high exactly one clk cycle, the first cycle of the new db value.
  - Never both high on the same channel.
- Latency: a clean input step becomes visible on db after 2 clk (sync) plus the STABLE-th following tick.
- Counter, per channel:
  - The event is rise, fall, or either, according to EDGE.
  - clr has priority: clr=1 forces cnt <= 0 and suppresses wrap, even with a simultaneous event.
  - On an event with cnt == MODULO-1: cnt <= 0 and wrap=1 for one cycle.
  - Otherwise on an event: cnt <= cnt+1.
  - The counter is gated by the filter only; en=0 stops ticks and therefore stops new events.
- Channels are fully independent; simultaneous events on several channels are all counted.
- Reset mid-operation: partial stability counts are discarded. db returns to 0 with no fall pulse generated.

Test Plan:
Sim configuration for all scenarios: CH=4, DIV_BITS=2 (tick every 4 clk), STABLE=3, MODULO=10, EDGE=0.
1. Reset: assert rst 3 cycles with sw=4'hF -> db, rise, fall, cnt, wrap and tick all 0 during reset and on the first cycle after.
2. Clean press: en=1, sw[0] 0->1 held -> db[0]=1 on the 3rd tick after the sync delay; rise[0] high exactly 1 cycle; cnt ch0 = 1; other channels unchanged.
3. Bounce rejection: sw[1] toggles every 5 clk for 60 clk, then held 0 -> db[1] stays 0, no rise[1], cnt ch1 = 0.
4. Wrap: 10 clean press/release cycles on sw[2] -> cnt ch2 steps 1..9 then 0; wrap[2] pulses once, on the 10th rise; 10 fall pulses seen.
5. Clear priority: hold clr[3]=1 across the cycle rise[3] fires -> cnt ch3 stays 0, wrap[3]=0. With EDGE=2 rebuild, one press+release gives cnt=2.
6. Enable / mid-op reset:
   - en=0 while sw[0] held high for 40 clk -> no tick, db[0] unchanged.
   - Set en=1 -> db[0] rises on the 3rd tick.
   - Assert rst after 2 of 3 qualifying ticks -> db=0, stab cleared, a full 3 ticks are required again afterwards.
